// File: rtl/aes_decrypt_core_basic_if.sv
// aes_decrypt_core_basic_if: start/finish handshake and data bus of the AES-128 decrypt core.
// Signals: start (1-cycle pulse), cipher_text/key (128b, byte 0 in [127:120]),
//          plain_text (128b), finish (result valid), bus_free (core idle or done).
interface aes_decrypt_core_basic_if;
  logic         start;
  logic [127:0] cipher_text;
  logic [127:0] key;
  logic [127:0] plain_text;
  logic         finish;
  logic         bus_free;

  modport master (
    output start, cipher_text, key,
    input  plain_text, finish, bus_free
  );

  modport slave (
    input  start, cipher_text, key,
    output plain_text, finish, bus_free
  );
endinterface

// File: rtl/aes_decrypt_core_basic.sv
// aes_decrypt_core_basic: iterative AES-128 decryption, one inverse round per clock.
// Ports: clk, nrst (async active-low), bus (slave modport of aes_decrypt_core_basic_if).
// Optional macro AES_DEC_KEY_CACHE_EN: caches rk10 of the last fully expanded key so a
// repeated key skips the forward key schedule.
module aes_decrypt_core_basic (
  input logic                     clk,
  input logic                     nrst,
  aes_decrypt_core_basic_if.slave bus
);
  // Purpose: AES-128 inverse cipher with on-the-fly backward key schedule.
  // Latency: 21 cycles start-to-finish (11 on a key-cache hit when the cache is built in).
  // Backpressure: none; start is accepted in any state and aborts work in progress.

  typedef enum logic [2:0] {S_IDLE, S_KEYEXP, S_ADDKEY, S_ROUND, S_DONE} state_t;

  state_t       r_fsm, w_fsm_nxt, w_load_fsm;
  logic [3:0]   r_rnd, w_load_rnd;
  logic [127:0] r_state, r_key, w_load_key;
  logic [31:0]  w_w0, w_w1, w_w2, w_w3, w_sw_in, w_sw_out, w_rcon_word;
  logic [31:0]  w_n0, w_n1, w_n2, w_n3;
  logic [127:0] w_key_fwd, w_key_inv, w_isb, w_ark, w_imc, w_round_out;

  // ---------------- GF(2^8) helpers (poly 0x11b) ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (bits 1..7 of the exponent set); maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r, base;
    r    = 8'h01;
    base = a;
    for (int i = 0; i < 8; i++) begin
      if (i != 0) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] b;
    b = ginv(a);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  // Inverse affine transform first, then field inverse.
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] b;
    b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
    return ginv(b);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // ---------------- key schedule (forward and backward share one SubWord) ----------------
  always_comb begin
    w_w0 = r_key[127:96];
    w_w1 = r_key[95:64];
    w_w2 = r_key[63:32];
    w_w3 = r_key[31:0];
    // Forward step substitutes w3; backward step substitutes the recovered w3 = w3^w2.
    w_sw_in     = (r_fsm == S_KEYEXP) ? w_w3 : (w_w3 ^ w_w2);
    w_sw_out    = {sbox(w_sw_in[23:16]), sbox(w_sw_in[15:8]),
                   sbox(w_sw_in[7:0]),   sbox(w_sw_in[31:24])};
    w_rcon_word = {rcon(r_rnd), 24'h000000};
    w_n0        = w_w0 ^ w_sw_out ^ w_rcon_word;
    w_n1        = w_w1 ^ w_n0;
    w_n2        = w_w2 ^ w_n1;
    w_n3        = w_w3 ^ w_n2;
    w_key_fwd   = {w_n0, w_n1, w_n2, w_n3};
    w_key_inv   = {w_w0 ^ w_sw_out ^ w_rcon_word, w_w1 ^ w_w0, w_w2 ^ w_w1, w_w3 ^ w_w2};
  end

  // ---------------- inverse round datapath ----------------
  always_comb begin
    w_isb = '0;
    // Byte (r, c) sits at index r + 4c; row r rotates right by r, so it takes column c-r.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_isb[8*(15-(r+4*c)) +: 8] = inv_sbox(r_state[8*(15-(r+4*((c+4-r)%4))) +: 8]);
      end
    end
    w_ark = w_isb ^ w_key_inv;
    w_imc = '0;
    for (int c = 0; c < 4; c++) begin
      w_imc[32*(3-c) +: 32] = inv_mix_col(w_ark[32*(3-c) +: 32]);
    end
    w_round_out = (r_rnd == 4'd1) ? w_ark : w_imc;
  end

`ifdef AES_DEC_KEY_CACHE_EN
  logic [127:0] r_okey, r_ckey, r_crk10;
  logic         r_cvld, w_cache_hit;

  assign w_cache_hit = r_cvld && (bus.key == r_ckey);

  // Cache is written only when a KEYEXP runs to completion without a new start.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_okey  <= '0;
      r_ckey  <= '0;
      r_crk10 <= '0;
      r_cvld  <= 1'b0;
    end else if (bus.start) begin
      r_okey <= bus.key;
    end else if (r_fsm == S_KEYEXP && r_rnd == 4'd10) begin
      r_ckey  <= r_okey;
      r_crk10 <= w_key_fwd;
      r_cvld  <= 1'b1;
    end
  end
`endif

  // What a start loads: the raw key (full expansion) or, on a cache hit, rk10 directly.
  always_comb begin
    w_load_key = bus.key;
    w_load_rnd = 4'd1;
    w_load_fsm = S_KEYEXP;
`ifdef AES_DEC_KEY_CACHE_EN
    if (w_cache_hit) begin
      w_load_key = r_crk10;
      w_load_rnd = 4'd10;
      w_load_fsm = S_ADDKEY;
    end
`endif
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) r_fsm <= S_IDLE;
    else       r_fsm <= w_fsm_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_fsm_nxt = r_fsm;
    if (bus.start) begin
      w_fsm_nxt = w_load_fsm;
    end else begin
      case (r_fsm)
        S_KEYEXP: if (r_rnd == 4'd10) w_fsm_nxt = S_ADDKEY;
        S_ADDKEY: w_fsm_nxt = S_ROUND;
        S_ROUND:  if (r_rnd == 4'd1) w_fsm_nxt = S_DONE;
        default:  w_fsm_nxt = r_fsm;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.finish   = (r_fsm == S_DONE);
    bus.bus_free = (r_fsm == S_IDLE) || (r_fsm == S_DONE);
  end

  assign bus.plain_text = r_state;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= '0;
      r_key   <= '0;
      r_rnd   <= 4'd0;
    end else if (bus.start) begin
      r_state <= bus.cipher_text;
      r_key   <= w_load_key;
      r_rnd   <= w_load_rnd;
    end else begin
      case (r_fsm)
        S_KEYEXP: begin
          r_key <= w_key_fwd;
          if (r_rnd != 4'd10) r_rnd <= r_rnd + 4'd1;
        end
        S_ADDKEY: begin
          r_state <= r_state ^ r_key;
          r_rnd   <= 4'd10;
        end
        S_ROUND: begin
          r_state <= w_round_out;
          r_key   <= w_key_inv;
          r_rnd   <= r_rnd - 4'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_decrypt_core_basic.sv
// tb_aes_decrypt_core_basic: directed and round-trip checks of the AES-128 decrypt core.
// Drives the interface on the falling edge and samples on the falling edge.
module tb_aes_decrypt_core_basic;
  logic clk  = 1'b0;
  logic nrst = 1'b0;

  aes_decrypt_core_basic_if bus ();

  aes_decrypt_core_basic dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

`ifdef AES_DEC_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t         vecs [8];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sb [256];
  logic [127:0] m_ckey = '0;
  bit           m_cvld = 1'b0;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward S-box from the generator-3 walk over GF(2^8)*.
  task automatic build_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int i = 0; i < 255; i++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  // Reference forward cipher used to make round-trip vectors.
  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s, k, t;
    logic [31:0]  tw;
    logic [7:0]   rc, a0, a1, a2, a3;
    s  = pt ^ key;
    k  = key;
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      tw = {sb[k[23:16]], sb[k[15:8]], sb[k[7:0]], sb[k[31:24]]} ^ {rc, 24'h0};
      k[127:96] = k[127:96] ^ tw;
      k[95:64]  = k[95:64] ^ k[127:96];
      k[63:32]  = k[63:32] ^ k[95:64];
      k[31:0]   = k[31:0] ^ k[63:32];
      rc = xt(rc);
      t = '0;
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[8*(15-(r+4*c)) +: 8] = sb[s[8*(15-(r+4*((c+r)%4))) +: 8]];
      if (rnd != 10) begin
        for (int c = 0; c < 4; c++) begin
          {a0, a1, a2, a3} = t[32*(3-c) +: 32];
          t[32*(3-c) +: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                               a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                               a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                               xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
      end
      s = t ^ k;
    end
    return s;
  endfunction

  task automatic launch(input logic [127:0] k, input logic [127:0] ct);
    bus.start       = 1'b1;
    bus.key         = k;
    bus.cipher_text = ct;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [127:0] k, input logic [127:0] ct,
                        input logic [127:0] pt, input int hold);
    int n;
    int lat;
    bit hit;
    hit = CACHE_ON && m_cvld && (k == m_ckey);
    lat = hit ? 11 : 21;
    launch(k, ct);
    check({name, " busy"}, 128'({bus.finish, bus.bus_free}), 128'd0);
    n = 0;
    while (!bus.finish && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({name, " latency"}, 128'(n), 128'(lat));
    check({name, " plain"}, bus.plain_text, pt);
    check({name, " bus_free"}, 128'(bus.bus_free), 128'd1);
    if (!hit) begin
      m_ckey = k;
      m_cvld = 1'b1;
    end
    repeat (hold) @(negedge clk);
    check({name, " hold"}, 128'({bus.finish, bus.bus_free}), 128'd3);
    check({name, " hold plain"}, bus.plain_text, pt);
  endtask

  initial begin
    logic [127:0] k, pt;
    bit any_fin;

    bus.start       = 1'b0;
    bus.key         = '0;
    bus.cipher_text = '0;
    build_sbox();

    vecs[0] = '{K_C1, CT_C1, PT_C1};
    vecs[1] = '{K_C1, CT_C1, PT_C1};
    vecs[2] = '{K_B,  CT_B,  PT_B};
    vecs[3] = '{K_B, 128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'h6bc1bee22e409f96e93d7e117393172a};
    vecs[4] = '{K_B, 128'hf5d3d58503b9699de785895a96fdbaaf, 128'hae2d8a571e03ac9c9eb76fac45af8e51};
    vecs[5] = '{K_B, 128'h43b1cd7f598ece23881b00e3ed030688, 128'h30c81c46a35ce411e5fbc1191a0a52ef};
    vecs[6] = '{K_B, 128'h7b0c785e27e8ad3f8223207104725dd4, 128'hf69f2445df4f9b17ad2b417be66c3710};
    vecs[7] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset plain", bus.plain_text, 128'd0);
    check("reset flags", 128'({bus.finish, bus.bus_free}), 128'd1);
    nrst = 1'b1;
    @(negedge clk);
    check("idle flags", 128'({bus.finish, bus.bus_free}), 128'd1);

    // Directed vectors, back-to-back (each start lands in DONE of the previous one)
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].key, vecs[i].ct, vecs[i].pt, 2);
    end

    // Abort: C.1 started, re-started with B seven edges later
    launch(K_C1, CT_C1);
    any_fin = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.finish || bus.bus_free) any_fin = 1'b1;
    end
    check("abort no early finish", 128'(any_fin), 128'd0);
    run_op("abort B", K_B, CT_B, PT_B, 1);

    // Reset in the middle of an operation
    launch(K_C1, CT_C1);
    repeat (14) @(negedge clk);
    nrst = 1'b0;
    m_cvld = 1'b0;
    #1;
    check("midreset plain", bus.plain_text, 128'd0);
    check("midreset flags", 128'({bus.finish, bus.bus_free}), 128'd1);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    check("post reset idle", 128'({bus.finish, bus.bus_free}), 128'd1);
    run_op("after reset C1", K_C1, CT_C1, PT_C1, 1);

    // Round trip against the reference forward cipher
    for (int i = 0; i < 12; i++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      run_op($sformatf("rt%0d", i), k, aes_enc(k, pt), pt, $urandom_range(1, 4));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_decrypt_core_basic.md
# aes_decrypt_core_basic

Iterative AES-128 decryption core, the inverse counterpart of the basic encryption core: accepts a 128-bit ciphertext and cipher key, produces the plaintext one round per clock. The forward key schedule is run first to reach round key 10, then round keys are regenerated backwards on the fly alongside the inverse rounds. It sits beside the encryption core behind the same start/finish handshake and shares its byte ordering and S-box/mix-column style.

## Interface
- No parameters.
- clk  input  1  clock, rising edge.
- nrst  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; samples cipher_text and key on that edge.
- cipher_text  input  128  ciphertext, byte 0 in [127:120], column-major state.
- key  input  128  AES-128 key, byte 0 in [127:120].
- plain_text  output  128  plaintext, same byte order; valid while finish=1.
- finish  output  1  high from completion until next start or reset.
- bus_free  output  1  high in IDLE and DONE: inputs are not needed and a start is accepted without aborting work.

## Operation
- One clock domain; reset is asynchronous and active-low.
- States: IDLE, KEYEXP, ADDKEY, ROUND, DONE. 4-bit round counter rnd.
- Reset: state IDLE, rnd=0, state/key registers 0, plain_text=0, finish=0, bus_free=1.
- start=1 in any state: latch cipher_text into state register, key into key register, enter KEYEXP (rnd=1). Start while busy aborts the current operation; no finish for it.
- KEYEXP: each cycle key register <= forward expansion step with Rcon[rnd] (01,02,04,08,10,20,40,80,1b,36); after rnd=10 step, key register holds rk10; go to ADDKEY.
- ADDKEY: state ^= rk10; rnd=10; go to ROUND.
- ROUND (rnd 10 down to 1): inverse key step with Rcon[rnd] gives rk(rnd-1): p3=w3^w2, p2=w2^w1, p1=w1^w0, p0=w0^SubWord(RotWord(p3))^Rcon[rnd].
  - rnd>1: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk(rnd-1)).
  - rnd=1: state <= InvSubBytes(InvShiftRows(state)) ^ rk0; go to DONE.
- InvShiftRows: row r rotated right by r. InvMixColumns coefficients 0e,0b,0d,09 in GF(2^8), poly 0x11b.
- DONE: plain_text = state register; finish=1; hold until start or reset.
- plain_text is driven directly from the state register; undefined-value-free but meaningful only when finish=1.

## Timing
- Start sampled at edge E0. KEYEXP edges E1–E10, ADDKEY E11, inverse rounds E12–E21. finish=1 after E21: latency 21 cycles start-to-finish.
- finish and bus_free deassert on the edge that samples start.
- Back-to-back: start during DONE is legal; finish drops the following cycle.
- Reset mid-operation: all registers clear immediately, no finish.

## Configuration
- AES_DEC_KEY_CACHE_EN defined: core keeps rk10 and the 128-bit key it derived from. On start, if key equals the cached key and cache is valid, KEYEXP is skipped (E0 loads state and rk10, ADDKEY at E1, rounds E2–E11): latency 11 cycles. Cache valid bit cleared by reset, set when KEYEXP completes; an aborted KEYEXP does not update the cache.
- Not defined: no cache registers; every operation takes 21 cycles.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a -> plain_text 00112233445566778899aabbccddeeff, finish exactly 21 cycles after start.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 -> 3243f6a8885a308d313198a2e0370734.
- Abort: start vector C.1, re-start at cycle 7 with vector B -> no finish before cycle 7+21; result B plaintext.
- Reset at cycle 15 of an operation -> plain_text=0, finish=0, bus_free=1 immediately; subsequent C.1 run correct.
- With AES_DEC_KEY_CACHE_EN: C.1 twice back-to-back -> second finish after 11 cycles; then vector B key -> 21 cycles; without macro both take 21.
- Random: 1000 keys/plaintexts encrypted by encryption core then decrypted -> round-trip equality, finish held until next start.
